// File: rtl/kiwi_trace_checker.sv
// kiwi_trace_checker
//
// Purpose:
//   Checks the trace stream of a KiwiC-generated regression test against a
//   golden stream. Each stream delivers one record per loop iteration,
//   {left, arrow1, arrow15}, with left in the MSBs. Records from the two
//   streams are buffered in small FIFOs and paired in arrival order. Each
//   pair is compared bit for bit. The block counts records and mismatches,
//   remembers the index of the first mismatch, and gives a pass/fail
//   verdict once NREC records have been compared or the run has stalled
//   for too long.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low (0 = in reset)
//   start      pulse; begins a run from IDLE or DONE, ignored while running
//   dut_valid  / dut_ready / dut_data   DUT trace record handshake
//   gld_valid  / gld_ready / gld_data   golden record handshake
//   busy       run in progress
//   done       run finished, verdict outputs are stable
//   pass       NREC records compared, no mismatch, no timeout
//   timed_out  run aborted because no compare happened for TIMEOUT cycles
//   rec_count  records compared this run
//   err_count  mismatching records, saturates at 255
//   first_err  index of the first mismatching record, 8'hFF if none
module kiwi_trace_checker #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int NREC    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  dut_valid,
  output logic                  dut_ready,
  input  logic [3*DATA_W-1:0]   dut_data,
  input  logic                  gld_valid,
  output logic                  gld_ready,
  input  logic [3*DATA_W-1:0]   gld_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timed_out,
  output logic [7:0]            rec_count,
  output logic [7:0]            err_count,
  output logic [7:0]            first_err
);

  localparam int REC_W = 3 * DATA_W;
  localparam int AW    = $clog2(DEPTH);
  localparam int PW    = AW + 1;
  localparam int TW    = $clog2(TIMEOUT) + 1;

  localparam logic [7:0]    NREC_B = 8'(NREC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;

  logic [REC_W-1:0] dut_mem [DEPTH];
  logic [REC_W-1:0] gld_mem [DEPTH];

  logic [PW-1:0] dut_wr, dut_rd, gld_wr, gld_rd;
  logic [TW-1:0] tcnt;

  logic dut_full, dut_empty, gld_full, gld_empty;
  logic dut_push, gld_push, do_cmp, mismatch;

  // The extra pointer MSB tells a full FIFO apart from an empty one when the
  // low (address) bits are equal.
  assign dut_full  = (dut_wr[AW] != dut_rd[AW]) && (dut_wr[AW-1:0] == dut_rd[AW-1:0]);
  assign gld_full  = (gld_wr[AW] != gld_rd[AW]) && (gld_wr[AW-1:0] == gld_rd[AW-1:0]);
  assign dut_empty = (dut_wr == dut_rd);
  assign gld_empty = (gld_wr == gld_rd);

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  // Ready depends only on fullness. A pop on the same edge does not free a
  // slot for a push, which keeps ready free of any path from the compare.
  assign dut_ready = busy && !dut_full;
  assign gld_ready = busy && !gld_full;

  assign dut_push = dut_valid && dut_ready;
  assign gld_push = gld_valid && gld_ready;

  // A compare only sees entries already stored, so a record pushed on one
  // edge is compared on a later edge at the earliest.
  assign do_cmp   = busy && !dut_empty && !gld_empty;
  assign mismatch = dut_mem[dut_rd[AW-1:0]] != gld_mem[gld_rd[AW-1:0]];

  // The FIFO storage has no reset. Stale contents are never read because the
  // pointers are cleared on reset and whenever a run starts.
  always_ff @(posedge clk) begin
    if (dut_push) dut_mem[dut_wr[AW-1:0]] <= dut_data;
    if (gld_push) gld_mem[gld_wr[AW-1:0]] <= gld_data;
  end

  // Run control: starting a run clears the FIFOs and the run statistics.
  // While running, records are pushed, pairs are compared, and the stall
  // counter is kept. The run ends on the NREC-th compare or on a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      dut_wr    <= '0;
      dut_rd    <= '0;
      gld_wr    <= '0;
      gld_rd    <= '0;
      tcnt      <= '0;
      pass      <= 1'b0;
      timed_out <= 1'b0;
      rec_count <= 8'd0;
      err_count <= 8'd0;
      first_err <= 8'hFF;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_RUN;
            dut_wr    <= '0;
            dut_rd    <= '0;
            gld_wr    <= '0;
            gld_rd    <= '0;
            tcnt      <= '0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
            rec_count <= 8'd0;
            err_count <= 8'd0;
            first_err <= 8'hFF;
          end
        end
        S_RUN: begin
          if (dut_push) dut_wr <= dut_wr + 1'b1;
          if (gld_push) gld_wr <= gld_wr + 1'b1;
          // A compare on the last allowed cycle wins over the timeout.
          if (do_cmp) begin
            dut_rd    <= dut_rd + 1'b1;
            gld_rd    <= gld_rd + 1'b1;
            rec_count <= rec_count + 8'd1;
            tcnt      <= '0;
            if (mismatch) begin
              if (err_count != 8'hFF) err_count <= err_count + 8'd1;
              if (err_count == 8'd0) first_err <= rec_count;
            end
            if (rec_count + 8'd1 == NREC_B) begin
              state <= S_DONE;
              pass  <= (err_count == 8'd0) && !mismatch;
            end
          end else if (tcnt == T_LAST) begin
            state     <= S_DONE;
            timed_out <= 1'b1;
            pass      <= 1'b0;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
